// File: rtl/mac_sequencer.sv
// mac_sequencer: LOAD/MAC sequencer accumulating N_TERMS 8x8 products; MAC_SATURATE_EN selects clamp+ovf over wrap
module mac_sequencer #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 20
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             start,
  input  logic [7:0]       a_in,
  input  logic [7:0]       b_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] res,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             ovf
);
  localparam int CW = $clog2(N_TERMS + 1);
  typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} state_t;
  state_t           state_q, state_d;
  logic [7:0]       a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_mac;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [15:0]      prod;
  assign prod = a_q * b_q;
`ifdef MAC_SATURATE_EN
  logic [ACC_W:0] sum;
  logic           ovf_q;
  assign sum     = {1'b0, acc_q} + (ACC_W + 1)'(prod);
  assign acc_mac = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  assign ovf     = ovf_q;
  // sticky overflow: cleared when a run starts, set by any clamped MAC step
  always_ff @(posedge CLK)
    if (R) ovf_q <= 1'b0;
    else if (state_q == IDLE && start) ovf_q <= 1'b0;
    else if (state_q == MAC && sum[ACC_W]) ovf_q <= 1'b1;
`else
  assign acc_mac = acc_q + ACC_W'(prod);
  assign ovf     = 1'b0;
`endif
  assign in_ready  = state_q == LOAD;
  assign res_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign res       = acc_q;
  // state, operand, accumulator and term-count registers
  always_ff @(posedge CLK)
    if (R) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  // next-state: LOAD and MAC alternate once per term until N_TERMS products are summed
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = LOAD;
      end
      LOAD: if (in_valid) begin
        a_d     = a_in;
        b_d     = b_in;
        state_d = MAC;
      end
      MAC: begin
        acc_d   = acc_mac;
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CW'(N_TERMS - 1) ? DONE : LOAD;
      end
      DONE: state_d = res_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: directed checks of a 20-bit and a 16-bit accumulator instance driven in lockstep
module tb_mac_sequencer;
  logic        CLK = 1'b0;
  logic        R = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  a_in = '0;
  logic [7:0]  b_in = '0;
  logic        in_valid = 1'b0;
  logic        res_ready = 1'b0;
  logic        in_ready20, res_valid20, busy20, ovf20;
  logic        in_ready16, res_valid16, busy16, ovf16;
  logic [19:0] res20;
  logic [15:0] res16;
  int          checks = 0;
  int          errors = 0;

  mac_sequencer #(.N_TERMS(4), .ACC_W(20)) u20 (
    .CLK(CLK), .R(R), .start(start), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
    .in_ready(in_ready20), .res(res20), .res_valid(res_valid20), .res_ready(res_ready),
    .busy(busy20), .ovf(ovf20)
  );

  mac_sequencer #(.N_TERMS(4), .ACC_W(16)) u16 (
    .CLK(CLK), .R(R), .start(start), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
    .in_ready(in_ready16), .res(res16), .res_valid(res_valid16), .res_ready(res_ready),
    .busy(busy16), .ovf(ovf16)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input string tag, input logic [3:0][7:0] a, input logic [3:0][7:0] b,
                     input int stall, input logic [19:0] exp);
    int n;
    n = 0;
    start = 1'b1;
    step(); n++;
    start = 1'b0;
    chk({tag, "_rdy"}, in_ready20, 1);
    for (int i = 0; i < 4; i++) begin
      for (int s = 0; s < stall; s++) begin
        in_valid = 1'b0;
        step(); n++;
        chk({tag, "_stall_rdy"}, in_ready20, 1);
      end
      a_in = a[i];
      b_in = b[i];
      in_valid = 1'b1;
      step(); n++;
      chk({tag, "_mac_rdy"}, in_ready20, 0);
      if (i == 3) chk({tag, "_pre_done"}, res_valid20, 0);
      step(); n++;
    end
    in_valid = 1'b0;
    chk({tag, "_lat"}, n, 9 + 4 * stall);
    chk({tag, "_valid"}, res_valid20, 1);
    chk({tag, "_res"}, res20, exp);
    chk({tag, "_busy"}, busy20, 1);
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    step();
    R = 1'b0;
    chk("rst_ready", in_ready20, 0);
    chk("rst_valid", res_valid20, 0);
    chk("rst_busy", busy20, 0);
    chk("rst_res", res20, 0);
    chk("rst_ovf", ovf16, 0);

    run("basic", {8'd7, 8'd5, 8'd3, 8'd1}, {8'd8, 8'd6, 8'd4, 8'd2}, 0, 20'd100);
    chk("basic_ovf", ovf20, 0);
    for (int c = 0; c < 5; c++) begin
      start = 1'b1;
      step();
      chk("hold_res", res20, 100);
      chk("hold_valid", res_valid20, 1);
    end
    start = 1'b0;
    release_res();
    chk("rel_valid", res_valid20, 0);
    chk("rel_busy", busy20, 0);
    step();
    step();
    chk("norun_busy", busy20, 0);
    chk("norun_ready", in_ready20, 0);

    run("stall", {8'd7, 8'd5, 8'd3, 8'd1}, {8'd8, 8'd6, 8'd4, 8'd2}, 3, 20'd100);
    release_res();

    res_ready = 1'b1;
    run("onecyc", {8'd1, 8'd1, 8'd1, 8'd1}, {8'd10, 8'd10, 8'd10, 8'd10}, 0, 20'd40);
    step();
    res_ready = 1'b0;
    chk("onecyc_drop", res_valid20, 0);

    run("wrap", {4{8'd255}}, {4{8'd255}}, 0, 20'd260100);
    chk("wrap20_ovf", ovf20, 0);
`ifdef MAC_SATURATE_EN
    chk("sat16_res", res16, 65535);
    chk("sat16_ovf", ovf16, 1);
`else
    chk("wrap16_res", res16, 63492);
    chk("wrap16_ovf", ovf16, 0);
`endif
    release_res();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ovf_clear", ovf16, 0);
    R = 1'b1;
    step();
    R = 1'b0;

    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    a_in = 8'd9;
    b_in = 8'd9;
    for (int i = 0; i < 4; i++) step();
    chk("mid_acc", res20, 162);
    R = 1'b1;
    step();
    R = 1'b0;
    in_valid = 1'b0;
    chk("mid_res", res20, 0);
    chk("mid_busy", busy20, 0);
    chk("mid_ready", in_ready20, 0);
    chk("mid_valid", res_valid20, 0);
    for (int c = 0; c < 6; c++) begin
      step();
      chk("mid_novalid", res_valid20, 0);
    end
    run("fresh", {4{8'd2}}, {4{8'd3}}, 0, 20'd24);
    release_res();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Control-and-datapath sequencer for the MAC unit. It accepts a stream of unsigned 8-bit operand pairs over a valid/ready handshake and latches each pair into its operand registers. It multiplies and accumulates exactly N_TERMS products, then presents the sum on a held result port until the consumer accepts it. It is the block that drives the MAC unit's eight-bit operand registers and the accumulator.

## Interface
- N_TERMS, 4: products accumulated per run; must be ≥ 1.
- ACC_W, 20: accumulator and result width; must be ≥ 16.

- CLK  in  1  rising-edge clock.
- R  in  1  synchronous, active-high reset.
- start  in  1  begins a run; sampled only in IDLE.
- a_in  in  8  operand A, unsigned.
- b_in  in  8  operand B, unsigned.
- in_valid  in  1  a_in/b_in valid.
- in_ready  out  1  sequencer can accept a pair.
- res  out  ACC_W  accumulated result.
- res_valid  out  1  res holds a completed run.
- res_ready  in  1  consumer accepts res.
- busy  out  1  high in any state other than IDLE.
- ovf  out  1  sticky overflow flag; constant 0 unless MAC_SATURATE_EN is defined.

## Operation
- State machine: IDLE, LOAD, MAC, DONE.
- IDLE:
  - in_ready=0, res_valid=0, busy=0.
  - start=1 → clear acc, count and ovf, then go to LOAD.
- LOAD:
  - in_ready=1.
  - in_valid=1 → latch a_in and b_in into the operand registers, then go to MAC.
  - in_valid=0 → stay in LOAD indefinitely.
- MAC:
  - in_ready=0.
  - acc ← acc + zero-extend(opA × opB), where the product is 16-bit unsigned.
  - count increments.
  - If count was N_TERMS−1 → DONE; otherwise → LOAD.
- DONE:
  - res_valid=1 and res=acc, both stable while res_ready=0.
  - res_ready=1 → IDLE. res_valid drops the next cycle.
- start is ignored outside IDLE. It is not queued.
- a_in/b_in are don't-care when in_valid=0 or in_ready=0.
- res equals acc in all states. It is meaningful only while res_valid=1.
- Default arithmetic: the sum wraps modulo 2^ACC_W.

## Timing
- Reset (R=1 at an edge):
  - state=IDLE; acc, count, operand registers and ovf = 0.
  - All outputs 0 the following cycle.
- R has priority over every other input.
- Reset mid-run: the run is discarded, no res_valid is produced, and the next start runs cleanly.
- start → in_ready=1 one cycle later.
- One pair is accepted per 2 cycles maximum (LOAD, MAC alternate).
- Result latency: handshake on edge k → MAC update on edge k+1 → res_valid=1 from the cycle after edge k+1.
- Minimum run length, start to res_valid: 2·N_TERMS+1 cycles.
- DONE with res_ready already high: res_valid is high for exactly one cycle.
- N_TERMS=1: the first MAC goes directly to DONE.

## Configuration
- MAC_SATURATE_EN defined:
  - If acc + product exceeds 2^ACC_W−1, acc clamps to 2^ACC_W−1 and ovf sets.
  - ovf is sticky until the next start or reset.
  - Once saturated, acc stays saturated for the rest of the run.
- MAC_SATURATE_EN undefined:
  - Modulo wrap as described in Operation.
  - ovf is tied to 0.
  - No saturation logic is synthesized.

## Test plan
- Basic run: N_TERMS=4, ACC_W=20, pairs (1,2),(3,4),(5,6),(7,8) with in_valid held high → res=100 and res_valid=1 at start+9 cycles; ovf=0.
- Back-pressure and start rejection: as the basic run, but res_ready=0 for 5 cycles and start pulsed during DONE → res stays 100 and res_valid stays 1; after res_ready=1, the FSM returns to IDLE, busy=0, and no new run begins.
- Input stalls: in_valid low for 3 cycles between each pair → in_ready holds 1 during the stalls; final res=100.
- Wrap (macro undefined): ACC_W=16, four pairs (255,255) → res=63492 (260100 mod 65536); ovf=0.
- Saturate (MAC_SATURATE_EN): ACC_W=16, four pairs (255,255) → res=65535, ovf=1; ovf clears on the next start.
- Reset mid-run: R=1 for one cycle after 2 pairs → outputs 0 and no res_valid; a fresh run with (2,3)×4 → res=24.
